// File: rtl/fp_add_sched.sv
// fp_add_sched: two-requester issue scheduler around a combinational single-precision adder.
// FP_ADD_SCHED_RR_EN selects round-robin tie-break; otherwise requester 0 always wins a tie.

module fp_add (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] s
);
  localparam int NEXP = 8;
  localparam int NSIG = 23;

  logic            sa, sb, a_nan, b_nan, a_inf, b_inf, swap;
  logic            big_s, sml_s, inc, sign_r;
  logic [NEXP-1:0] ea, eb, ex_a, ex_b, ex_big, ex_sml, d;
  logic [NSIG-1:0] fa, fb;
  logic [NSIG:0]   m_a, m_b, m_big, m_sml;
  logic [49:0]     sh;
  logic [26:0]     w_big, w_sml, n;
  logic [27:0]     sum;
  logic [4:0]      lz;
  logic [8:0]      e_n, lim, lz9, shamt;
  logic [31:0]     rnd;

  always_comb begin
    sa = a[31];
    sb = b[31];
    ea = a[30:23];
    eb = b[30:23];
    fa = a[22:0];
    fb = b[22:0];
    a_nan = (&ea) & (|fa);
    b_nan = (&eb) & (|fb);
    a_inf = (&ea) & ~(|fa);
    b_inf = (&eb) & ~(|fb);
    // subnormals share the minimum exponent with a zero hidden bit
    ex_a = (ea == '0) ? 8'd1 : ea;
    ex_b = (eb == '0) ? 8'd1 : eb;
    m_a  = {|ea, fa};
    m_b  = {|eb, fb};
    swap = {eb, fb} > {ea, fa};
    big_s  = swap ? sb : sa;
    sml_s  = swap ? sa : sb;
    ex_big = swap ? ex_b : ex_a;
    ex_sml = swap ? ex_a : ex_b;
    m_big  = swap ? m_b : m_a;
    m_sml  = swap ? m_a : m_b;
    d      = ex_big - ex_sml;

    // align the smaller operand, keeping guard/round and a sticky of everything shifted out
    sh    = {m_sml, 26'b0} >> d;
    w_sml = {sh[49:24], (|sh[23:0]) | ((d > 8'd49) & (|m_sml))};
    w_big = {m_big, 3'b000};
    if (big_s == sml_s) sum = {1'b0, w_big} + {1'b0, w_sml};
    else                sum = {1'b0, w_big} - {1'b0, w_sml};

    lz = 5'd27;
    for (int i = 0; i <= 26; i++) begin
      if (sum[i]) lz = 5'(26 - i);
    end

    lim   = {1'b0, ex_big} - 9'd1;
    lz9   = {4'b0, lz};
    shamt = 9'd0;
    if (sum[27]) begin
      n   = {sum[27:2], sum[1] | sum[0]};
      e_n = {1'b0, ex_big} + 9'd1;
    end else begin
      // left shift stops at the minimum exponent so tiny results stay subnormal
      shamt = (lz9 > lim) ? lim : lz9;
      n     = sum[26:0] << shamt;
      e_n   = {1'b0, ex_big} - shamt;
    end

    // round to nearest even; the carry out of the fraction bumps the exponent field
    inc    = n[2] & (n[1] | n[0] | n[3]);
    rnd    = {(n[26] ? e_n : 9'd0), n[25:3]} + {31'b0, inc};
    sign_r = (sum == '0) ? (sa & sb) : big_s;

    if (a_nan)                        s = a;
    else if (b_nan)                   s = b;
    else if (a_inf & b_inf & (sa != sb)) s = 32'h7FFF_FFFF;
    else if (a_inf)                   s = a;
    else if (b_inf)                   s = b;
    else if (rnd[31:23] >= 9'd255)    s = {sign_r, 8'hFF, 23'b0};
    else                              s = {sign_r, rnd[30:0]};
  end
endmodule

module fp_add_sched #(
  parameter int TAGW = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic [1:0]      req_valid,
  output logic [1:0]      req_ready,
  input  logic [31:0]     req_a0,
  input  logic [31:0]     req_a1,
  input  logic [31:0]     req_b0,
  input  logic [31:0]     req_b1,
  input  logic [1:0]      req_sub,
  input  logic [TAGW-1:0] req_tag0,
  input  logic [TAGW-1:0] req_tag1,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [31:0]     res_s,
  output logic            res_id,
  output logic [TAGW-1:0] res_tag,
  output logic            busy
);
  logic            s1_v, s1_id;
  logic [31:0]     s1_a, s1_b, sum;
  logic [TAGW-1:0] s1_tag, sel_tag;
  logic [1:0]      grant;
  logic            s1_can_accept, s2_load, accept, sel, sel_sub;
  logic [31:0]     sel_a, sel_b;

`ifdef FP_ADD_SCHED_RR_EN
  logic ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      ptr <= 1'b0;
    else if (accept) ptr <= ~sel;
  end

  assign grant[0] = req_valid[0] & (~req_valid[1] | ~ptr);
  assign grant[1] = req_valid[1] & (~req_valid[0] | ptr);
`else
  assign grant[0] = req_valid[0];
  assign grant[1] = req_valid[1] & ~req_valid[0];
`endif

  assign s2_load       = s1_v & (~res_valid | res_ready);
  assign s1_can_accept = ~s1_v | ~res_valid | res_ready;
  assign req_ready     = grant & {2{s1_can_accept & ~flush}};
  assign accept        = |req_ready;
  assign sel           = req_ready[1];
  assign sel_a         = sel ? req_a1 : req_a0;
  assign sel_b         = sel ? req_b1 : req_b0;
  assign sel_tag       = sel ? req_tag1 : req_tag0;
  assign sel_sub       = req_sub[sel];
  assign busy          = s1_v | res_valid;

  fp_add u_fp_add (
    .a (s1_a),
    .b (s1_b),
    .s (sum)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v   <= 1'b0;
      s1_a   <= '0;
      s1_b   <= '0;
      s1_id  <= 1'b0;
      s1_tag <= '0;
    end else if (flush) begin
      s1_v <= 1'b0;
    end else if (accept) begin
      s1_v   <= 1'b1;
      s1_a   <= sel_a;
      // subtraction is an add with B's sign flipped, NaN payloads included
      s1_b   <= {sel_b[31] ^ sel_sub, sel_b[30:0]};
      s1_id  <= sel;
      s1_tag <= sel_tag;
    end else if (s2_load) begin
      s1_v <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid <= 1'b0;
      res_s     <= '0;
      res_id    <= 1'b0;
      res_tag   <= '0;
    end else if (flush) begin
      res_valid <= 1'b0;
    end else if (s2_load) begin
      res_valid <= 1'b1;
      res_s     <= sum;
      res_id    <= s1_id;
      res_tag   <= s1_tag;
    end else if (res_ready) begin
      res_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_fp_add_sched.sv
// Directed bench for fp_add_sched: a queue-based scoreboard predicts handshakes and results each cycle.
module tb_fp_add_sched;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic [1:0]  req_valid = 2'b00;
  logic [1:0]  req_ready;
  logic [31:0] req_a0 = '0, req_a1 = '0, req_b0 = '0, req_b1 = '0;
  logic [1:0]  req_sub = 2'b00;
  logic [3:0]  req_tag0 = '0, req_tag1 = '0;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [31:0] res_s;
  logic        res_id;
  logic [3:0]  res_tag;
  logic        busy;

  fp_add_sched #(.TAGW(4)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a0(req_a0), .req_a1(req_a1), .req_b0(req_b0), .req_b1(req_b1),
    .req_sub(req_sub), .req_tag0(req_tag0), .req_tag1(req_tag1),
    .res_valid(res_valid), .res_ready(res_ready), .res_s(res_s),
    .res_id(res_id), .res_tag(res_tag), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] a; logic [31:0] b; logic sub; logic [3:0] tag; logic [31:0] e; } op_t;
  typedef struct { logic [31:0] s; logic id; logic [3:0] tag; int t; } exp_t;

  op_t  src0[$];
  op_t  src1[$];
  exp_t mq[$];
  int   grant_log[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  logic mptr = 1'b0;
  logic en0 = 1'b0, en1 = 1'b0, rr_req = 1'b0, fl_req = 1'b0;
  int   exp_g[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic add_op(input int r, input logic [31:0] a, input logic [31:0] b,
                        input logic sub, input logic [3:0] tag, input logic [31:0] e);
    op_t o;
    o.a = a; o.b = b; o.sub = sub; o.tag = tag; o.e = e;
    if (r == 0) src0.push_back(o);
    else        src1.push_back(o);
  endtask

  task automatic drive();
    req_valid[0] = en0 && (src0.size() > 0);
    req_valid[1] = en1 && (src1.size() > 0);
    if (src0.size() > 0) begin
      req_a0 = src0[0].a; req_b0 = src0[0].b; req_sub[0] = src0[0].sub; req_tag0 = src0[0].tag;
    end
    if (src1.size() > 0) begin
      req_a1 = src1[0].a; req_b1 = src1[0].b; req_sub[1] = src1[0].sub; req_tag1 = src1[0].tag;
    end
    res_ready = rr_req;
    flush     = fl_req;
  endtask

  task automatic step();
    @(posedge clk); #1; drive();
    @(negedge clk); #1;
  endtask

  // Scoreboard: at most two ops in flight, oldest becomes visible two cycles after acceptance.
  always @(negedge clk) begin
    logic       head_vis, can, v0, v1;
    int         win;
    logic [1:0] exp_rdy;
    exp_t       ent;
    op_t        o;
    if (!rst_n) begin
      chk("rst_res_valid", {31'b0, res_valid}, 32'd0);
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_req_ready", {30'b0, req_ready}, 32'd0);
      chk("rst_res_s", res_s, 32'd0);
      mq.delete();
      mptr = 1'b0;
    end else begin
      head_vis = (mq.size() > 0) && (cyc >= mq[0].t + 2);
      can      = !flush && ((mq.size() < 2) || res_ready);
      v0       = req_valid[0];
      v1       = req_valid[1];
`ifdef FP_ADD_SCHED_RR_EN
      win = (v0 && v1) ? int'(mptr) : (v1 ? 1 : 0);
`else
      win = v0 ? 0 : 1;
`endif
      exp_rdy = (can && (v0 || v1)) ? 2'(1 << win) : 2'b00;
      chk("req_ready", {30'b0, req_ready}, {30'b0, exp_rdy});
      chk("busy", {31'b0, busy}, {31'b0, mq.size() > 0});
      chk("res_valid", {31'b0, res_valid}, {31'b0, head_vis});
      if (head_vis) begin
        chk("res_s", res_s, mq[0].s);
        chk("res_id", {31'b0, res_id}, {31'b0, mq[0].id});
        chk("res_tag", {28'b0, res_tag}, {28'b0, mq[0].tag});
        if (res_ready) void'(mq.pop_front());
      end
      if (exp_rdy != 2'b00) begin
        o = (win == 1) ? src1.pop_front() : src0.pop_front();
        ent.s = o.e; ent.id = (win == 1); ent.tag = o.tag; ent.t = cyc;
        mq.push_back(ent);
        grant_log.push_back(win);
        mptr = (win == 0);
      end
      if (flush) mq.delete();
    end
    cyc++;
  end

  initial begin
    repeat (2) @(negedge clk);
    #1;
    chk("reset_res_valid", {31'b0, res_valid}, 32'd0);
    chk("reset_busy", {31'b0, busy}, 32'd0);
    @(posedge clk); #1; rst_n = 1'b1;

    // single add
    rr_req = 1'b1; en0 = 1'b1;
    add_op(0, 32'h3F800000, 32'h40000000, 1'b0, 4'd5, 32'h40400000);
    step(); chk("add_accept", {30'b0, req_ready}, 32'd1);
    step(); chk("add_t1_valid", {31'b0, res_valid}, 32'd0);
    step();
    chk("add_t2_valid", {31'b0, res_valid}, 32'd1);
    chk("add_t2_s", res_s, 32'h40400000);
    chk("add_t2_id", {31'b0, res_id}, 32'd0);
    chk("add_t2_tag", {28'b0, res_tag}, 32'd5);

    // subtract from requester 1
    en1 = 1'b1;
    add_op(1, 32'h3F800000, 32'h3F800000, 1'b1, 4'd2, 32'h00000000);
    add_op(1, 32'h40400000, 32'h3F800000, 1'b1, 4'd3, 32'h40000000);
    step(); chk("sub_accept", {30'b0, req_ready}, 32'd2);
    repeat (5) step();

    // contention
    grant_log.delete();
    add_op(0, 32'h3F800000, 32'h3F800000, 1'b0, 4'd0, 32'h40000000);
    add_op(0, 32'h40000000, 32'h40000000, 1'b0, 4'd1, 32'h40800000);
    add_op(0, 32'h3F800000, 32'h40000000, 1'b0, 4'd2, 32'h40400000);
    add_op(0, 32'h40800000, 32'h40800000, 1'b0, 4'd3, 32'h41000000);
    add_op(1, 32'h3F000000, 32'h3F000000, 1'b0, 4'd4, 32'h3F800000);
    add_op(1, 32'h3FC00000, 32'h3F000000, 1'b0, 4'd5, 32'h40000000);
    add_op(1, 32'h40000000, 32'h3F000000, 1'b1, 4'd6, 32'h3FC00000);
    add_op(1, 32'h41000000, 32'h40000000, 1'b1, 4'd7, 32'h40C00000);
    repeat (12) step();
`ifdef FP_ADD_SCHED_RR_EN
    exp_g = '{0, 1, 0, 1, 0, 1, 0, 1};
`else
    exp_g = '{0, 0, 0, 0, 1, 1, 1, 1};
`endif
    chk("grant_count", grant_log.size(), 32'd8);
    if (grant_log.size() == 8)
      for (int i = 0; i < 8; i++) chk("grant_order", grant_log[i], exp_g[i]);

    // backpressure
    en1 = 1'b0; rr_req = 1'b0;
    add_op(0, 32'h40800000, 32'h40800000, 1'b0, 4'd8, 32'h41000000);
    add_op(0, 32'h3F800000, 32'h00000000, 1'b0, 4'd9, 32'h3F800000);
    add_op(0, 32'h40000000, 32'h40800000, 1'b1, 4'd10, 32'hC0000000);
    step(); chk("bp_acc1", {30'b0, req_ready}, 32'd1);
    step(); chk("bp_acc2", {30'b0, req_ready}, 32'd1);
    step(); chk("bp_full", {30'b0, req_ready}, 32'd0);
    repeat (5) begin
      step();
      chk("bp_hold_s", res_s, 32'h41000000);
      chk("bp_hold_rdy", {30'b0, req_ready}, 32'd0);
    end
    rr_req = 1'b1;
    step(); chk("bp_release_accept", {30'b0, req_ready}, 32'd1);
    repeat (5) step();

    // flush with two in flight
    rr_req = 1'b0;
    add_op(0, 32'h3F800000, 32'h3F800000, 1'b0, 4'd11, 32'h40000000);
    add_op(0, 32'h40000000, 32'h40000000, 1'b0, 4'd12, 32'h40800000);
    add_op(0, 32'h40400000, 32'h3F800000, 1'b0, 4'd13, 32'h40800000);
    step(); step();
    fl_req = 1'b1; rr_req = 1'b1;
    step(); chk("flush_no_accept", {30'b0, req_ready}, 32'd0);
    fl_req = 1'b0;
    step();
    chk("flush_res_valid", {31'b0, res_valid}, 32'd0);
    chk("flush_busy", {31'b0, busy}, 32'd0);
    repeat (4) step();

    // asynchronous reset mid-operation
    rr_req = 1'b0;
    add_op(0, 32'h3F800000, 32'h3F800000, 1'b0, 4'd14, 32'h40000000);
    add_op(0, 32'h40000000, 32'h3F800000, 1'b0, 4'd15, 32'h40400000);
    step(); step();
    src0.delete();
    @(posedge clk); #1; drive();
    #2; rst_n = 1'b0;
    #1;
    chk("arst_res_valid", {31'b0, res_valid}, 32'd0);
    chk("arst_busy", {31'b0, busy}, 32'd0);
    chk("arst_res_s", res_s, 32'd0);
    chk("arst_res_tag", {28'b0, res_tag}, 32'd0);
    chk("arst_res_id", {31'b0, res_id}, 32'd0);
    @(negedge clk);
    @(posedge clk); #1; rst_n = 1'b1; rr_req = 1'b1; drive();
    repeat (3) step();
    chk("arst_no_result", {31'b0, res_valid}, 32'd0);

    // special values and rounding
    add_op(0, 32'h7F800000, 32'hFF800000, 1'b0, 4'd1, 32'h7FFFFFFF);
    add_op(0, 32'h3F800000, 32'h7FC00000, 1'b1, 4'd2, 32'hFFC00000);
    add_op(0, 32'h3F800000, 32'h33800000, 1'b0, 4'd3, 32'h3F800000);
    add_op(0, 32'h3F800000, 32'h34400000, 1'b0, 4'd4, 32'h3F800002);
    add_op(0, 32'h00000001, 32'h00000001, 1'b0, 4'd5, 32'h00000002);
    add_op(0, 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 4'd6, 32'h7F800000);
    repeat (10) step();

    chk("drain_model_empty", mq.size(), 32'd0);
    chk("drain_src_empty", src0.size() + src1.size(), 32'd0);
    chk("drain_busy", {31'b0, busy}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
